// File: rtl/fc_result_reader_pkg.sv
// Shared definitions for the FC result readout stage: FSM state encoding,
// arithmetic-type encodings and the float sign-bit position.
package fc_result_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } fc_state_e;

  localparam int ARITH_FIXED = 0;
  localparam int ARITH_FLOAT = 1;

  // Sign bit of an IEEE-754 single-precision word.
  localparam int FLOAT_SIGN_BIT = 31;

endpackage

// File: rtl/fc_max_compare.sv
// Combinational strict "a > b" for FC scores. Fixed point compares as signed
// two's complement; float compares by sign/magnitude with +0 == -0.
module fc_max_compare
  import fc_result_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ARITH_TYPE = ARITH_FIXED
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  gt_o
);

  if (ARITH_TYPE == ARITH_FLOAT) begin : g_float
    logic                      sa, sb;
    logic [FLOAT_SIGN_BIT-1:0] ma, mb;

    assign sa = a_i[FLOAT_SIGN_BIT];
    assign sb = b_i[FLOAT_SIGN_BIT];
    assign ma = a_i[FLOAT_SIGN_BIT-1:0];
    assign mb = b_i[FLOAT_SIGN_BIT-1:0];

    // Sign/magnitude ordering; two zeros of any sign are equal.
    always_comb begin
      gt_o = 1'b0;
      if ((ma == '0) && (mb == '0)) begin
        gt_o = 1'b0;
      end else if (sa != sb) begin
        gt_o = !sa;
      end else if (!sa) begin
        gt_o = (ma > mb);
      end else begin
        gt_o = (ma < mb);
      end
    end
  end else begin : g_fixed
    assign gt_o = ($signed(a_i) > $signed(b_i));
  end

endmodule

// File: rtl/fc_result_reader.sv
// FC result readout: snapshots NUM_CLASSES accumulator outputs on start,
// streams them one beat per handshake and reports the argmax class.
// Optional macro FC_ARGMAX_EN enables running-max tracking, class_index and
// class_valid; without it those outputs are tied to 0.
//
// Handshake: a beat transfers on a cycle where out_valid && out_ready; while
// out_valid is high and out_ready low, out_data/out_index/out_last hold.
module fc_result_reader
  import fc_result_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ARITH_TYPE  = ARITH_FIXED,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] data_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [IDX_W-1:0]                  out_index,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done,
  output logic [IDX_W-1:0]                  class_index,
  output logic                              class_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  // Elaboration-time parameter sanity checks.
  if ((NUM_CLASSES < 2) || (NUM_CLASSES > 16)) begin : g_bad_classes
    $error("fc_result_reader: NUM_CLASSES must be in 2..16");
  end
  if ((1 << IDX_W) < NUM_CLASSES) begin : g_bad_idx_w
    $error("fc_result_reader: IDX_W too narrow for NUM_CLASSES");
  end
  if ((ARITH_TYPE == ARITH_FLOAT) && (DATA_WIDTH != 32)) begin : g_bad_float
    $error("fc_result_reader: float scores require DATA_WIDTH = 32");
  end

  fc_state_e             state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] snap_q [NUM_CLASSES];
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  hs;

  assign cur_data = snap_q[idx_q];

  // Outputs decoded straight from state and registers.
  assign out_valid = (state_q == ST_STREAM);
  assign out_data  = cur_data;
  assign out_index = idx_q;
  assign out_last  = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign hs        = out_valid && out_ready;

  // Readout FSM: snapshot on start, step index per accepted beat, pulse done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              snap_q[i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
            idx_q   <= '0;
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FC_ARGMAX_EN
  logic [DATA_WIDTH-1:0] max_val_q;
  logic [IDX_W-1:0]      max_idx_q;
  logic                  max_vld_q;
  logic [IDX_W-1:0]      class_index_q;
  logic                  class_valid_q;
  logic                  gt;
  logic                  take_d;

  fc_max_compare #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARITH_TYPE (ARITH_TYPE)
  ) u_cmp (
    .a_i  (cur_data),
    .b_i  (max_val_q),
    .gt_o (gt)
  );

  // First beat always loads; later beats only when strictly greater.
  assign take_d = !max_vld_q || gt;

  // Running max per frame; the result is committed on the last handshake so
  // class_index is already updated in the done cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_val_q     <= '0;
      max_idx_q     <= '0;
      max_vld_q     <= 1'b0;
      class_index_q <= '0;
      class_valid_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        max_vld_q <= 1'b0;
      end else if (hs && take_d) begin
        max_val_q <= cur_data;
        max_idx_q <= idx_q;
        max_vld_q <= 1'b1;
      end
      if (hs && out_last) begin
        class_index_q <= take_d ? idx_q : max_idx_q;
        class_valid_q <= 1'b1;
      end
    end
  end

  assign class_index = class_index_q;
  assign class_valid = class_valid_q;
`else
  assign class_index = '0;
  assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fc_result_reader.sv
// Bench for fc_result_reader: a fixed-point instance exercised with directed
// frames (streaming, backpressure, snapshot isolation, mid-frame reset) and a
// float instance exercised for argmax ordering.
module tb_fc_result_reader;

  localparam int NC = 10;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int BW = IW + DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             fix_start = 1'b0;
  logic [NC*DW-1:0] fix_din   = '0;
  logic             fix_valid, fix_last, fix_busy, fix_done, fix_cvalid;
  logic             fix_ready = 1'b1;
  logic [DW-1:0]    fix_data;
  logic [IW-1:0]    fix_index, fix_cidx;

  logic             flt_start = 1'b0;
  logic [NC*DW-1:0] flt_din   = '0;
  logic             flt_valid, flt_last, flt_busy, flt_done, flt_cvalid;
  logic [DW-1:0]    flt_data;
  logic [IW-1:0]    flt_index, flt_cidx;

  fc_result_reader #(.DATA_WIDTH(DW), .ARITH_TYPE(0), .NUM_CLASSES(NC), .IDX_W(IW)) u_fix (
    .clk(clk), .reset(reset), .start(fix_start), .data_in(fix_din),
    .out_valid(fix_valid), .out_ready(fix_ready), .out_data(fix_data),
    .out_index(fix_index), .out_last(fix_last), .busy(fix_busy), .done(fix_done),
    .class_index(fix_cidx), .class_valid(fix_cvalid)
  );

  fc_result_reader #(.DATA_WIDTH(DW), .ARITH_TYPE(1), .NUM_CLASSES(NC), .IDX_W(IW)) u_flt (
    .clk(clk), .reset(reset), .start(flt_start), .data_in(flt_din),
    .out_valid(flt_valid), .out_ready(1'b1), .out_data(flt_data),
    .out_index(flt_index), .out_last(flt_last), .busy(flt_busy), .done(flt_done),
    .class_index(flt_cidx), .class_valid(flt_cvalid)
  );

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];       // {index, data, last} per expected beat
  logic [IW:0]   exp_done_q[$];  // {class_valid, class_index} per fixed frame
  logic [IW:0]   exp_flt_q[$];   // {class_valid, class_index} per float frame
  logic [DW-1:0] frame_v [NC];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            beat_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [NC*DW-1:0] pack_frame();
    logic [NC*DW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*DW +: DW] = frame_v[i];
    return r;
  endfunction

  task automatic chk_fix_zero(input string tag);
    chk({tag, "_valid"}, 64'(fix_valid), 0);
    chk({tag, "_data"},  64'(fix_data),  0);
    chk({tag, "_index"}, 64'(fix_index), 0);
    chk({tag, "_last"},  64'(fix_last),  0);
    chk({tag, "_busy"},  64'(fix_busy),  0);
    chk({tag, "_done"},  64'(fix_done),  0);
    chk({tag, "_cidx"},  64'(fix_cidx),  0);
    chk({tag, "_cvalid"}, 64'(fix_cvalid), 0);
  endtask

  // ---------------- monitors ----------------
  // Beat monitor: presented beat must match the queue head, stalled or not.
  always @(negedge clk) begin
    if (reset && fix_valid) begin
      if (exp_q.size() == 0) begin
        flag("beat_unexpected");
      end else begin
        chk("beat", 64'({fix_index, fix_data, fix_last}), 64'(exp_q[0]));
        if (fix_ready) begin
          void'(exp_q.pop_front());
          beat_cnt++;
        end
      end
    end
  end

  // Done monitor for the fixed instance.
  always @(negedge clk) begin
    if (reset && fix_done) begin
      if (exp_done_q.size() == 0) begin
        flag("done_unexpected");
      end else begin
        chk("fix_class", 64'({fix_cvalid, fix_cidx}), 64'(exp_done_q.pop_front()));
        chk("beat_count", 64'(beat_cnt), 64'(NC));
        chk("beats_left", 64'(exp_q.size()), 0);
        beat_cnt = 0;
      end
    end
  end

  // Done monitor for the float instance.
  always @(negedge clk) begin
    if (reset && flt_done) begin
      if (exp_flt_q.size() == 0) flag("flt_done_unexpected");
      else chk("flt_class", 64'({flt_cvalid, flt_cidx}), 64'(exp_flt_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  task automatic push_beats();
    for (int i = 0; i < NC; i++)
      exp_q.push_back({IW'(i), frame_v[i], (i == NC - 1)});
  endtask

  task automatic run_frame_fix(input logic [IW-1:0] cls, input bit bp, input bit interfere);
    logic [3:0] bp_pat;
    int         n;
    bp_pat = 4'b1001;
    push_beats();
`ifdef FC_ARGMAX_EN
    exp_done_q.push_back({1'b1, cls});
`else
    exp_done_q.push_back({1'b0, IW'(0)});
`endif
    fix_ready = 1'b1;
    fix_din   = pack_frame();
    fix_start = 1'b1;
    @(posedge clk); #1;
    fix_start = 1'b0;
    fix_din   = '0;                 // accumulator bank cleared after start
    chk("valid_c1", 64'(fix_valid), 1);
    chk("busy_c1",  64'(fix_busy),  1);
    n = 1;
    while (!fix_done && n < 200) begin
      if (bp) fix_ready = bp_pat[n % 4];
      fix_start = interfere && (n == 3);
      if (interfere && n == 3) fix_din = ~pack_frame();
      @(posedge clk); #1;
      n++;
    end
    fix_start = 1'b0;
    fix_ready = 1'b1;
    if (n >= 200) flag("done_timeout");
    else if (!bp) chk("done_cycle", 64'(n), 11);
    @(posedge clk); #1;
    chk("idle_busy",  64'(fix_busy),  0);
    chk("idle_valid", 64'(fix_valid), 0);
  endtask

  task automatic run_frame_flt(input logic [IW-1:0] cls);
    int n;
`ifdef FC_ARGMAX_EN
    exp_flt_q.push_back({1'b1, cls});
`else
    exp_flt_q.push_back({1'b0, IW'(0)});
`endif
    flt_din   = pack_frame();
    flt_start = 1'b1;
    @(posedge clk); #1;
    flt_start = 1'b0;
    flt_din   = '0;
    n = 1;
    while (!flt_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) flag("flt_done_timeout");
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #12;
    chk_fix_zero("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Fixed-point stream, tie at index 4 resolves to 2.
    frame_v = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd3, 32'd4};
    run_frame_fix(4'd2, 1'b0, 1'b0);

    // Backpressure: -100,50,50,-7,12,49,0,3,-2,1 -> index 1.
    frame_v = '{32'hFFFF_FF9C, 32'd50, 32'd50, 32'hFFFF_FFF9, 32'd12, 32'd49, 32'd0, 32'd3, 32'hFFFF_FFFE, 32'd1};
    run_frame_fix(4'd1, 1'b1, 1'b0);

    // Snapshot isolation with start pulse mid-stream: 0,-1..-9 -> index 0.
    frame_v = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC,
                32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 32'hFFFF_FFF7};
    run_frame_fix(4'd0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Extreme signed values, max on the last index.
    frame_v = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    run_frame_fix(4'd9, 1'b0, 1'b0);

    // Reset after the 4th accepted beat.
    frame_v = '{32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    push_beats();
    fix_din   = pack_frame();
    fix_start = 1'b1;
    @(posedge clk); #1;
    fix_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("beats_before_reset", 64'(exp_q.size()), 6);
    reset = 1'b0;
    #1;
    chk_fix_zero("midrst");
    exp_q.delete();
    beat_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    frame_v = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd3, 32'd4};
    run_frame_fix(4'd2, 1'b0, 1'b0);

    // Float: -2.0 everywhere, class 3 = -0.5, class 6 = 1.25 -> 6.
    for (int i = 0; i < NC; i++) frame_v[i] = 32'hC000_0000;
    frame_v[3] = 32'hBF00_0000;
    frame_v[6] = 32'h3FA0_0000;
    run_frame_flt(4'd6);
    // All -0.0 except class 8 = +0.0 -> 0.
    for (int i = 0; i < NC; i++) frame_v[i] = 32'h8000_0000;
    frame_v[8] = 32'h0000_0000;
    run_frame_flt(4'd0);
    // Both negative: -2.0 everywhere, class 5 = -1.0, class 7 = -3.0 -> 5.
    for (int i = 0; i < NC; i++) frame_v[i] = 32'hC000_0000;
    frame_v[5] = 32'hBF80_0000;
    frame_v[7] = 32'hC040_0000;
    run_frame_flt(4'd5);
    // Both positive: 1.0 everywhere, class 2 = 2.0, class 4 = 3.0 -> 4.
    for (int i = 0; i < NC; i++) frame_v[i] = 32'h3F80_0000;
    frame_v[2] = 32'h4000_0000;
    frame_v[4] = 32'h4040_0000;
    run_frame_flt(4'd4);

    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_empty",    64'(exp_q.size()), 0);
    chk("done_q_empty",   64'(exp_done_q.size()), 0);
    chk("flt_q_empty",    64'(exp_flt_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
